// File: rtl/gps_translation_field_parse.sv
// Parses one ASCII NMEA numeric field (e.g. "4807.038," or "-12.5*") into a
// signed 32-bit fixed-point integer scaled by 10^FRAC_DIGITS.
//
// Ports:
//   ap_clk, ap_rst      clock and synchronous active-high reset
//   in_data/in_valid    ASCII byte stream; in_ready is the accept strobe
//   out_value           signed result, 0 when out_err or out_empty
//   out_empty           terminator arrived before any other character
//   out_err             malformed field or magnitude overflow
//   out_term            character that closed the field
//   out_valid/out_ready result handshake
module gps_translation_field_parse #(
  parameter int unsigned FRAC_DIGITS = 4
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_value,
  output logic        out_empty,
  output logic        out_err,
  output logic [7:0]  out_term,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [2:0] FracMax = FRAC_DIGITS[2:0];
  localparam logic [35:0] MaxMag = 36'h0_7FFF_FFFF;

  typedef enum logic [2:0] {
    S_INT,
    S_FRAC,
    S_PAD,
    S_OUT,
    S_SKIP
  } state_e;

  state_e      state_q, state_d;
  logic [32:0] mag_q, mag_d;
  logic        neg_q, neg_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        seen_q, seen_d;
  logic        dig_q, dig_d;
  logic        err_q, err_d;
  logic        empty_q, empty_d;
  logic [7:0]  term_q, term_d;

  logic        in_xfer;
  logic        is_digit;
  logic        is_term;
  logic        is_minus;
  logic        is_dot;
  logic [35:0] mag_ext;
  logic [35:0] mul10;
  logic [35:0] digit_sum;
  logic        ovf_digit;
  logic        ovf_pad;

  assign in_ready = ~ap_rst &
                    ((state_q == S_INT) | (state_q == S_FRAC) | (state_q == S_SKIP));
  assign in_xfer  = in_valid & in_ready;

  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_term  = (in_data == 8'h2C) || (in_data == 8'h2A) ||
                    (in_data == 8'h0D) || (in_data == 8'h0A);
  assign is_minus = (in_data == 8'h2D);
  assign is_dot   = (in_data == 8'h2E);

  // Widened so that an overflowing multiply is still detected exactly.
  assign mag_ext   = {3'b000, mag_q};
  assign mul10     = (mag_ext << 3) + (mag_ext << 1);
  assign digit_sum = mul10 + {32'd0, in_data[3:0]};
  assign ovf_digit = digit_sum > MaxMag;
  assign ovf_pad   = mul10 > MaxMag;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    fcnt_d  = fcnt_q;
    seen_d  = seen_q;
    dig_d   = dig_q;
    err_d   = err_q;
    empty_d = empty_q;
    term_d  = term_q;

    case (state_q)
      S_INT, S_FRAC: begin
        if (in_xfer) begin
          if (is_term) begin
            term_d  = in_data;
            state_d = S_PAD;
            if (!seen_q) begin
              empty_d = 1'b1;
            end else if (!dig_q) begin
              // Lone sign or dot: flagged here, no skipping needed.
              err_d = 1'b1;
            end
          end else begin
            seen_d = 1'b1;
            if (is_digit) begin
              dig_d = 1'b1;
              if (state_q == S_INT || fcnt_q < FracMax) begin
                if (ovf_digit) begin
                  err_d   = 1'b1;
                  state_d = S_SKIP;
                end else begin
                  mag_d = digit_sum[32:0];
                  if (state_q == S_FRAC) begin
                    fcnt_d = fcnt_q + 3'd1;
                  end
                end
              end
              // Surplus fractional digits fall through and are dropped.
            end else if (state_q == S_INT && is_minus && !seen_q) begin
              neg_d = 1'b1;
            end else if (state_q == S_INT && is_dot) begin
              state_d = S_FRAC;
            end else begin
              err_d   = 1'b1;
              state_d = S_SKIP;
            end
          end
        end
      end

      S_PAD: begin
        if (fcnt_q == FracMax) begin
          state_d = S_OUT;
        end else if (ovf_pad) begin
          err_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          mag_d  = mul10[32:0];
          fcnt_d = fcnt_q + 3'd1;
        end
      end

      S_SKIP: begin
        if (in_xfer && is_term) begin
          term_d  = in_data;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (out_ready) begin
          mag_d   = '0;
          neg_d   = 1'b0;
          fcnt_d  = '0;
          seen_d  = 1'b0;
          dig_d   = 1'b0;
          err_d   = 1'b0;
          empty_d = 1'b0;
          term_d  = '0;
          state_d = S_INT;
        end
      end

      default: begin
        state_d = S_INT;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_INT;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      fcnt_q  <= '0;
      seen_q  <= 1'b0;
      dig_q   <= 1'b0;
      err_q   <= 1'b0;
      empty_q <= 1'b0;
      term_q  <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      fcnt_q  <= fcnt_d;
      seen_q  <= seen_d;
      dig_q   <= dig_d;
      err_q   <= err_d;
      empty_q <= empty_d;
      term_q  <= term_d;
    end
  end

  // Outputs are forced to zero outside S_OUT so idle values are clean.
  always_comb begin
    out_valid = (state_q == S_OUT);
    out_empty = out_valid & empty_q;
    out_err   = out_valid & err_q;
    out_term  = out_valid ? term_q : 8'h00;
    out_value = 32'd0;
    if (out_valid && !err_q && !empty_q) begin
      out_value = neg_q ? (~mag_q[31:0] + 32'd1) : mag_q[31:0];
    end
  end

endmodule

// File: tb/tb_gps_translation_field_parse.sv
module tb_gps_translation_field_parse;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_value;
  logic        out_empty;
  logic        out_err;
  logic [7:0]  out_term;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] r_val;
  logic        r_err;
  logic        r_empty;
  logic [7:0]  r_term;
  int          r_lat;
  logic        r_rdy;

  gps_translation_field_parse #(.FRAC_DIGITS(4)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_value (out_value),
    .out_empty (out_empty),
    .out_err   (out_err),
    .out_term  (out_term),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout byte=%02h got in_ready=0 want 1", b);
    end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Waits for out_valid, captures the result, then lets the handshake happen
  // if out_ready is high. r_rdy records whether in_ready was ever seen high.
  task automatic wait_result(input bit consume);
    r_lat = 0;
    r_rdy = 1'b0;
    while (!out_valid && r_lat < 40) begin
      if (in_ready) r_rdy = 1'b1;
      @(posedge ap_clk); #1;
      r_lat++;
    end
    if (in_ready) r_rdy = 1'b1;
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL result_timeout got out_valid=0 want 1");
    end
    r_val   = out_value;
    r_err   = out_err;
    r_empty = out_empty;
    r_term  = out_term;
    if (consume) begin
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic test_reset;
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++;
      $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if ({out_value, out_err, out_empty, out_term} !== 42'd0) begin n_bad++;
      $display("FAIL rst_outputs got %h/%b/%b/%h want 0", out_value, out_err, out_empty,
               out_term); end
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++;
      $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    send_str("4807.038,");
    wait_result(1'b1);
    n_cmp++; if (r_val !== 32'd48070380) begin n_bad++;
      $display("FAIL basic_value got %0d want 48070380", $signed(r_val)); end
    n_cmp++; if ({r_err, r_empty, r_term} !== {2'b00, 8'h2C}) begin n_bad++;
      $display("FAIL basic_flags got err=%b empty=%b term=%h want 0/0/2c", r_err, r_empty,
               r_term); end
    n_cmp++; if (r_lat !== 2) begin n_bad++;
      $display("FAIL basic_latency got %0d want 2", r_lat); end
  endtask

  task automatic test_negative;
    send_str("-12.5*");
    wait_result(1'b1);
    n_cmp++; if (r_val !== 32'hFFFE17B8) begin n_bad++;
      $display("FAIL neg_value got %h want fffe17b8", r_val); end
    n_cmp++; if ({r_err, r_empty, r_term} !== {2'b00, 8'h2A}) begin n_bad++;
      $display("FAIL neg_flags got err=%b empty=%b term=%h want 0/0/2a", r_err, r_empty,
               r_term); end
    n_cmp++; if (r_lat !== 4) begin n_bad++;
      $display("FAIL neg_latency got %0d want 4", r_lat); end
    n_cmp++; if (r_rdy !== 1'b0) begin n_bad++;
      $display("FAIL neg_in_ready_pad got %b want 0", r_rdy); end
  endtask

  task automatic test_empty;
    for (int k = 0; k < 2; k++) begin
      send_byte(8'h2C);
      wait_result(1'b1);
      n_cmp++; if ({r_val, r_empty, r_err} !== {32'd0, 2'b10}) begin n_bad++;
        $display("FAIL empty_%0d got val=%h empty=%b err=%b want 0/1/0", k, r_val, r_empty,
                 r_err); end
    end
    send_str("-,");
    wait_result(1'b1);
    n_cmp++; if ({r_val, r_empty, r_err} !== {32'd0, 2'b01}) begin n_bad++;
      $display("FAIL sign_only got val=%h empty=%b err=%b want 0/0/1", r_val, r_empty,
               r_err); end
  endtask

  task automatic test_malformed;
    string fields [4] = '{".,", "1-2,", "1.2.3,", "1a\r"};
    foreach (fields[k]) begin
      send_str(fields[k]);
      wait_result(1'b1);
      n_cmp++; if ({r_val, r_err, r_empty} !== {32'd0, 2'b10}) begin n_bad++;
        $display("FAIL malformed_%0d got val=%h err=%b empty=%b want 0/1/0", k, r_val, r_err,
                 r_empty); end
    end
    n_cmp++; if (r_term !== 8'h0D) begin n_bad++;
      $display("FAIL malformed_term got %h want 0d", r_term); end
    send_str("5.\n");
    wait_result(1'b1);
    n_cmp++; if ({r_val, r_err, r_term} !== {32'd50000, 1'b0, 8'h0A}) begin n_bad++;
      $display("FAIL trailing_dot got val=%0d err=%b term=%h want 50000/0/0a", r_val, r_err,
               r_term); end
  endtask

  task automatic test_overflow;
    send_str("2147483648xy,");
    wait_result(1'b1);
    n_cmp++; if ({r_val, r_err, r_term} !== {32'd0, 1'b1, 8'h2C}) begin n_bad++;
      $display("FAIL ovf_int got val=%h err=%b term=%h want 0/1/2c", r_val, r_err, r_term); end
    send_str("7,");
    wait_result(1'b1);
    n_cmp++; if ({r_val, r_err} !== {32'd70000, 1'b0}) begin n_bad++;
      $display("FAIL after_ovf got val=%0d err=%b want 70000/0", r_val, r_err); end
    n_cmp++; if (r_lat !== 5) begin n_bad++;
      $display("FAIL after_ovf_latency got %0d want 5", r_lat); end
    send_str("214748.3647,");
    wait_result(1'b1);
    n_cmp++; if ({r_val, r_err} !== {32'h7FFFFFFF, 1'b0}) begin n_bad++;
      $display("FAIL max_pos got val=%h err=%b want 7fffffff/0", r_val, r_err); end
    send_str("-214748.3647,");
    wait_result(1'b1);
    n_cmp++; if ({r_val, r_err} !== {32'h80000001, 1'b0}) begin n_bad++;
      $display("FAIL max_neg got val=%h err=%b want 80000001/0", r_val, r_err); end
    send_str("-214748.3648,");
    wait_result(1'b1);
    n_cmp++; if ({r_val, r_err} !== {32'd0, 1'b1}) begin n_bad++;
      $display("FAIL min_neg got val=%h err=%b want 0/1", r_val, r_err); end
  endtask

  task automatic test_truncate;
    send_str("1.234567,");
    wait_result(1'b1);
    n_cmp++; if ({r_val, r_err} !== {32'd12345, 1'b0}) begin n_bad++;
      $display("FAIL truncate got val=%0d err=%b want 12345/0", r_val, r_err); end
    n_cmp++; if (r_lat !== 1) begin n_bad++;
      $display("FAIL truncate_latency got %0d want 1", r_lat); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send_str("9.5,");
    // Next field's first byte is presented while the result is stalled.
    in_data  = 8'h33;
    in_valid = 1'b1;
    wait_result(1'b0);
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if ({out_valid, out_value, out_err, out_empty, out_term, in_ready} !==
                   {1'b1, 32'd95000, 2'b00, 8'h2C, 1'b0}) begin n_bad++;
        $display("FAIL stall_%0d got v=%b val=%0d err=%b empty=%b term=%h rdy=%b", c,
                 out_valid, out_value, out_err, out_empty, out_term, in_ready); end
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b1;
    send_byte(8'h33);
    send_byte(8'h2C);
    wait_result(1'b1);
    n_cmp++; if ({r_val, r_err, r_empty} !== {32'd30000, 2'b00}) begin n_bad++;
      $display("FAIL after_stall got val=%0d err=%b empty=%b want 30000/0/0", r_val, r_err,
               r_empty); end
  endtask

  task automatic test_reset_mid;
    logic saw_valid;
    send_str("12");
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) saw_valid = 1'b1;
      @(posedge ap_clk); #1;
    end
    n_cmp++; if (saw_valid !== 1'b0) begin n_bad++;
      $display("FAIL aborted_field got out_valid=1 want 0"); end
    send_str("3,");
    wait_result(1'b1);
    n_cmp++; if ({r_val, r_err, r_empty} !== {32'd30000, 2'b00}) begin n_bad++;
      $display("FAIL reset_mid got val=%0d err=%b empty=%b want 30000/0/0", r_val, r_err,
               r_empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_empty();
    test_malformed();
    test_overflow();
    test_truncate();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gps_translation_field_parse.md
Name: gps_translation_field_parse

Overview:
Upstream feeder of the translation multiplier stage. Consumes the ASCII byte stream of one NMEA numeric field (for example "4807.038," or "-12.5*") and converts it to a signed 32-bit fixed-point integer scaled by 10^FRAC_DIGITS. It emits the value, status flags and the terminating character over a valid/ready handshake. The value is the 32-bit signed operand consumed by the downstream scale multiply.

Parameters:
FRAC_DIGITS, 4, number of fractional decimal digits retained; legal range 0..7; shorter fractions are zero-padded, extra digits are ignored.

Ports:
ap_clk  in  1  clock; all logic on rising edge
ap_rst  in  1  synchronous, active-high reset
in_data  in  8  ASCII character
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
out_value  out  32  signed result = round-toward-zero(field × 10^FRAC_DIGITS); 0 when out_err or out_empty
out_empty  out  1  field contained no characters before the terminator
out_err  out  1  malformed field or magnitude overflow
out_term  out  8  terminator character that closed the field
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result

Behaviour:
- Transfer rules: an input byte transfers when in_valid & in_ready; a result transfers when out_valid & out_ready.
- State register values: S_INT, S_FRAC, S_PAD, S_OUT, S_SKIP. Reset state is S_INT.
- Reset: in_ready=0 during the reset cycle and 1 the cycle after. out_valid=0, out_value=0, out_empty=0, out_err=0, out_term=0. Accumulator, sign and digit counters are cleared. Reset mid-field discards the partial field without producing output.
- Internal datapath: accumulator mag is unsigned 33 bits. neg flag. fcnt counts fractional digits (0..FRAC_DIGITS). seen flag means any char consumed; dig flag means any digit consumed.
- Terminators: ',' '*' CR (0x0D) LF (0x0A).
- in_ready=1 in S_INT, S_FRAC and S_SKIP; 0 in S_PAD and S_OUT.
- S_INT:
  - digit d: mag ← mag×10 + d, computed as (mag<<3)+(mag<<1)+d.
  - '-' as the first char: neg←1. '-' anywhere else → error.
  - '.' → S_FRAC.
  - terminator → S_PAD.
  - any other char → error.
- S_FRAC:
  - digit with fcnt<FRAC_DIGITS: mag ← mag×10+d, fcnt++.
  - digit with fcnt=FRAC_DIGITS: ignored (truncation).
  - terminator → S_PAD.
  - second '.', '-' or other char → error.
  - FRAC_DIGITS=0: all fractional digits are ignored.
- S_PAD: one cycle per missing digit, mag ← mag×10, fcnt++, until fcnt=FRAC_DIGITS, then S_OUT. If fcnt already equals FRAC_DIGITS at the terminator, S_PAD lasts exactly one cycle with no multiply.
- Latency: out_valid rises (FRAC_DIGITS − fcnt_at_terminator) + 1 cycles after the terminator transfer.
- Overflow: if any update makes mag > 2^31−1, that is an error. −2^31 is not representable and is also flagged.
- Error handling: on error go to S_SKIP. The offending char is consumed; if the offending char is itself a terminator condition (overflow on the terminator is impossible), skipping is not needed. S_SKIP consumes and discards bytes until a terminator, then → S_OUT with out_err=1, out_value=0.
- Sign/dot without digits: a field with seen=1 and dig=0 (e.g. "-," or ".,") → out_err=1.
- Empty field: terminator as the first char → out_empty=1, out_err=0, out_value=0, passing through S_PAD normally.
- S_OUT:
  - out_value = neg ? −mag : mag (32-bit two's complement). out_term = the latched terminator.
  - Outputs hold stable while out_valid & !out_ready.
  - On transfer: clear the accumulator, neg, fcnt, seen, dig and flags; → S_INT. in_ready rises the following cycle.
- No bubble is required beyond the above; sustained rate is one byte per cycle while parsing.

Test Plan:
- FRAC_DIGITS=4, bytes "4807.038," at one per cycle, out_ready=1 → out_value=48070380, out_term=0x2C, err=0, empty=0, out_valid 2 cycles after ',' accepted.
- "-12.5*" → out_value=−125000 (0xFFFE17B8), out_term=0x2A, 4 cycles terminator-to-valid, in_ready=0 throughout S_PAD/S_OUT.
- ",," → two results, each out_empty=1, out_value=0; "-," → out_err=1, empty=0.
- "2147483648," → out_err=1, out_value=0, trailing bytes up to ',' swallowed; next field "7," → 70000 clean. "1.234567," → 12345 (extra digits truncated).
- Backpressure: out_ready=0 for 5 cycles after valid → value and flags stable, in_ready=0, no input byte lost (in_valid held with the next field's first byte, which is accepted after the handshake).
- Assert ap_rst for one cycle after "12" mid-field, then send "3," → out_value=30000, no output generated for the aborted field.
